program_counter_v2: RTL
=======================

PROGRAM_COUNTER_V2 -- requirements
Module: program_counter_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning address width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of valid addresses, 2 <= DEPTH <= 2**WIDTH.
REQ-003 SHALL have parameter SKIP_FIRST, default 1, meaning the first accepted ce after reset arms the counter without advancing it.
REQ-004 SHALL have port clk  input  1  meaning sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port ce  input  1  meaning count enable.
REQ-007 SHALL have port stall  input  1  meaning freeze; cnt holds while high.
REQ-008 SHALL have port ld  input  1  meaning absolute jump request.
REQ-009 SHALL have port ld_addr  input  WIDTH  meaning jump target.
REQ-010 SHALL have port br  input  1  meaning relative branch request.
REQ-011 SHALL have port br_off  input  WIDTH  meaning two's-complement branch offset.
REQ-012 SHALL have port halt  input  1  meaning stop counting until the next ld.
REQ-013 SHALL have port cnt  output  WIDTH  meaning current address, registered.
REQ-014 SHALL have port running  output  1  meaning state is RUN, registered.
REQ-015 SHALL have port wrap  output  1  meaning one-cycle pulse when an increment wraps DEPTH-1 to 0.
REQ-016 SHALL have port err  output  1  meaning one-cycle pulse when ld or br targets an address >= DEPTH.

Function
REQ-017 SHALL implement states IDLE, RUN and HALTED; reset state is IDLE.
REQ-018 In IDLE, ce=1 and stall=0 SHALL move to RUN; cnt holds if SKIP_FIRST=1, else cnt increments in the same cycle.
REQ-019 In IDLE, ld, br and halt SHALL be ignored.
REQ-020 In RUN with stall=0 and ce=1, the per-cycle priority SHALL be halt > ld > br > increment.
REQ-021 halt in RUN SHALL move to HALTED with cnt held.
REQ-022 ld SHALL set cnt=ld_addr on the next edge when ld_addr < DEPTH; otherwise cnt holds and err pulses.
REQ-023 br SHALL set cnt=(cnt+br_off) mod 2**WIDTH when the result is < DEPTH; otherwise cnt holds and err pulses.
REQ-024 increment SHALL set cnt=cnt+1, except cnt=DEPTH-1 goes to 0 with wrap=1 for that cycle.
REQ-025 stall=1 or ce=0 SHALL hold cnt and state, and SHALL keep wrap=0 and err=0.
REQ-026 In HALTED, only ld with ce=1 and stall=0 SHALL act: a valid target loads cnt and returns to RUN; an invalid target pulses err and stays in HALTED.
REQ-027 wrap and err SHALL never both be 1 in the same cycle.
REQ-028 Every output SHALL change only on a clock edge or on rstn assertion; there is no combinational input-to-output path.

Reset
REQ-029 rstn=0 SHALL immediately force cnt=0, running=0, wrap=0, err=0 and state IDLE, regardless of clk.
REQ-030 Reset asserted mid-operation, including while HALTED or mid-wrap, SHALL discard all state; after release, the SKIP_FIRST arming rule applies again.
REQ-031 Reset release SHALL be followed by at least one clk edge before ce is honoured.

Structure
REQ-032 Shared package pc_pkg SHALL hold the state enum typedef (IDLE/RUN/HALTED) and the default WIDTH/DEPTH constants.
REQ-033 Next-address arithmetic (increment/wrap, load check, branch add and range check) SHALL be one combinational sub-module, pc_next_calc, instantiated once.
REQ-034 State register and output registers SHALL reside in program_counter_v2.

Verification (WIDTH=5, DEPTH=20, SKIP_FIRST=1)
REQ-035 Reset release, then ce=1 for 4 cycles -> cnt 0,0,1,2,3 (first ce arms only); running=1 from cycle 1.
REQ-036 cnt=19, ce=1 -> cnt=0 with wrap=1 for exactly one cycle; next cycle cnt=1, wrap=0.
REQ-037 cnt=5, br=1 with br_off=5'b11110 (-2) -> cnt=3; cnt=5 with br_off=20 -> cnt holds at 5, err=1 for one cycle.
REQ-038 cnt=7, halt=1 and ld=1 in the same cycle -> HALTED, cnt=7; then ld=1 with ld_addr=25 -> err=1, still HALTED; then ld_addr=12 -> RUN, cnt=12.
REQ-039 cnt=9 with stall=1 and ld=1 for 3 cycles -> cnt stays 9, no err; stall drop with ld still high -> cnt=ld_addr.
REQ-040 rstn=0 asynchronously mid-cycle while RUN at cnt=14 -> cnt=0 and running=0 immediately; after release, the first ce does not advance cnt.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: FSM state type and default geometry.
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEF = 5;
  localparam int unsigned PC_DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-address candidates: increment with wrap, jump range check,
// and relative branch sum with range check.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH_DEF,
  parameter int unsigned DEPTH = PC_DEPTH_DEF
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0] br_off,
  output logic [WIDTH-1:0] inc_addr_c,
  output logic             inc_wrap_c,
  output logic             ld_ok_c,
  output logic [WIDTH-1:0] br_addr_c,
  output logic             br_ok_c
);

  // One extra bit so DEPTH == 2**WIDTH is representable in the range compare.
  localparam logic [WIDTH:0]   DEPTH_W   = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(DEPTH - 1);

  always_comb begin
    inc_wrap_c = (cnt == LAST_ADDR);
    inc_addr_c = inc_wrap_c ? '0 : cnt + WIDTH'(1);
    // Sum truncates to WIDTH bits, giving the mod 2**WIDTH behaviour for free.
    br_addr_c  = cnt + br_off;
    ld_ok_c    = ({1'b0, ld_addr} < DEPTH_W);
    br_ok_c    = ({1'b0, br_addr_c} < DEPTH_W);
  end

endmodule

// File: rtl/program_counter_v2.sv
// Program counter with arm-on-first-enable, halt, absolute jump and relative branch;
// all outputs registered.
module program_counter_v2
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH      = PC_WIDTH_DEF,
  parameter int unsigned DEPTH      = PC_DEPTH_DEF,
  parameter bit          SKIP_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ce,
  input  logic             stall,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic             br,
  input  logic [WIDTH-1:0] br_off,
  input  logic             halt,
  output logic [WIDTH-1:0] cnt,
  output logic             running,
  output logic             wrap,
  output logic             err
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] inc_addr_c;
  logic             inc_wrap_c;
  logic             ld_ok_c;
  logic [WIDTH-1:0] br_addr_c;
  logic             br_ok_c;
  logic             act_c;

  pc_next_calc #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_next (
    .cnt        (cnt_q),
    .ld_addr    (ld_addr),
    .br_off     (br_off),
    .inc_addr_c (inc_addr_c),
    .inc_wrap_c (inc_wrap_c),
    .ld_ok_c    (ld_ok_c),
    .br_addr_c  (br_addr_c),
    .br_ok_c    (br_ok_c)
  );

  assign act_c = ce & ~stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end

  // Next state and next outputs; wrap/err are single-cycle pulses by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    if (act_c) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          if (!SKIP_FIRST) begin
            cnt_d  = inc_addr_c;
            wrap_d = inc_wrap_c;
          end
        end

        ST_RUN: begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (ld) begin
            if (ld_ok_c) cnt_d = ld_addr;
            else         err_d = 1'b1;
          end else if (br) begin
            if (br_ok_c) cnt_d = br_addr_c;
            else         err_d = 1'b1;
          end else begin
            cnt_d  = inc_addr_c;
            wrap_d = inc_wrap_c;
          end
        end

        ST_HALTED: begin
          if (ld) begin
            if (ld_ok_c) begin
              cnt_d   = ld_addr;
              state_d = ST_RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  assign cnt     = cnt_q;
  assign running = running_q;
  assign wrap    = wrap_q;
  assign err     = err_q;

endmodule
